// File: rtl/map_table_if.sv
// Dispatch-stage rename bus between the dispatch logic (master) and the map table (slave).
// Valid-only handshake: D_en_k, cdb_en_k, br_wr_en_k and br_mispredict are qualifiers sampled every cycle; there is no ready/back-pressure, the map answers combinationally in the same cycle.
interface map_table_if;
  logic       D_en_1, D_en_2;
  logic [4:0] dest_1, dest_2;
  logic [4:0] srcA_1, srcB_1, srcA_2, srcB_2;
  logic [5:0] fl_T_1, fl_T_2;
  logic       cdb_en_1, cdb_en_2;
  logic [5:0] cdb_tag_1, cdb_tag_2;
  logic       br_wr_en_1, br_wr_en_2;
  logic [2:0] br_marker_in_1, br_marker_in_2;
  logic       br_mispredict;
  logic [2:0] br_mispre_marker;
  logic [5:0] tagA_1, tagB_1, tagA_2, tagB_2;
  logic       rdyA_1, rdyB_1, rdyA_2, rdyB_2;
  logic [5:0] Told_1, Told_2;

  modport master (
    output D_en_1, D_en_2, dest_1, dest_2,
    output srcA_1, srcB_1, srcA_2, srcB_2,
    output fl_T_1, fl_T_2,
    output cdb_en_1, cdb_en_2, cdb_tag_1, cdb_tag_2,
    output br_wr_en_1, br_wr_en_2, br_marker_in_1, br_marker_in_2,
    output br_mispredict, br_mispre_marker,
    input  tagA_1, tagB_1, tagA_2, tagB_2,
    input  rdyA_1, rdyB_1, rdyA_2, rdyB_2,
    input  Told_1, Told_2
  );

  modport slave (
    input  D_en_1, D_en_2, dest_1, dest_2,
    input  srcA_1, srcB_1, srcA_2, srcB_2,
    input  fl_T_1, fl_T_2,
    input  cdb_en_1, cdb_en_2, cdb_tag_1, cdb_tag_2,
    input  br_wr_en_1, br_wr_en_2, br_marker_in_1, br_marker_in_2,
    input  br_mispredict, br_mispre_marker,
    output tagA_1, tagB_1, tagA_2, tagB_2,
    output rdyA_1, rdyB_1, rdyA_2, rdyB_2,
    output Told_1, Told_2
  );
endinterface

// File: rtl/map_table.sv
// Two-wide register rename map (32 arch -> 64 phys) with per-physical ready bits and
// marker-indexed branch checkpoints that restore the whole map in one cycle.
module map_table #(
  parameter int         NUM_CKPT = 4,
  parameter logic [5:0] ZERO_TAG = 6'd31
) (
  input logic        clock,
  input logic        reset,
  map_table_if.slave bus
);

  localparam int CKPT_W = $clog2(NUM_CKPT);

  logic [5:0]  map_q   [32];
  logic [63:0] ready_q;
  logic [5:0]  ckpt_q  [NUM_CKPT][32];

  logic [5:0]  map_mid [32];
  logic [5:0]  map_all [32];
  logic [5:0]  map_d   [32];
  logic [63:0] ready_d;

  logic [CKPT_W-1:0] mark_1, mark_2, mark_mis;
  logic              ckpt_wr_1, ckpt_wr_2;
  logic              fwd_a2, fwd_b2, same_dest;
  logic              unused_marker_bits;

  assign mark_1   = bus.br_marker_in_1[CKPT_W-1:0];
  assign mark_2   = bus.br_marker_in_2[CKPT_W-1:0];
  assign mark_mis = bus.br_mispre_marker[CKPT_W-1:0];
  assign unused_marker_bits = ^{bus.br_marker_in_1[2:CKPT_W], bus.br_marker_in_2[2:CKPT_W],
                                bus.br_mispre_marker[2:CKPT_W]};

  // Checkpoint writes are dropped when both slots claim one, or when a restore is in flight.
  assign ckpt_wr_1 = bus.br_wr_en_1 && !bus.br_wr_en_2 && !bus.br_mispredict;
  assign ckpt_wr_2 = bus.br_wr_en_2 && !bus.br_wr_en_1 && !bus.br_mispredict;

  // Ready with same-cycle CDB bypass; the zero register's tag is always available.
  function automatic logic tag_ready(input logic [5:0]  tag,
                                     input logic [63:0] rdy_vec,
                                     input logic        c_en_1,
                                     input logic [5:0]  c_tag_1,
                                     input logic        c_en_2,
                                     input logic [5:0]  c_tag_2);
    return rdy_vec[tag] || (c_en_1 && (c_tag_1 == tag)) || (c_en_2 && (c_tag_2 == tag))
           || (tag == ZERO_TAG);
  endfunction

  // Slot 2 sees slot 1's new mapping before it reaches the table.
  assign fwd_a2    = bus.D_en_1 && (bus.srcA_2 == bus.dest_1);
  assign fwd_b2    = bus.D_en_1 && (bus.srcB_2 == bus.dest_1);
  assign same_dest = bus.D_en_1 && (bus.dest_2 == bus.dest_1);

  assign bus.tagA_1 = map_q[bus.srcA_1];
  assign bus.tagB_1 = map_q[bus.srcB_1];
  assign bus.tagA_2 = fwd_a2 ? bus.fl_T_1 : map_q[bus.srcA_2];
  assign bus.tagB_2 = fwd_b2 ? bus.fl_T_1 : map_q[bus.srcB_2];

  assign bus.rdyA_1 = tag_ready(bus.tagA_1, ready_q, bus.cdb_en_1, bus.cdb_tag_1,
                                bus.cdb_en_2, bus.cdb_tag_2);
  assign bus.rdyB_1 = tag_ready(bus.tagB_1, ready_q, bus.cdb_en_1, bus.cdb_tag_1,
                                bus.cdb_en_2, bus.cdb_tag_2);
  assign bus.rdyA_2 = !fwd_a2 && tag_ready(bus.tagA_2, ready_q, bus.cdb_en_1, bus.cdb_tag_1,
                                           bus.cdb_en_2, bus.cdb_tag_2);
  assign bus.rdyB_2 = !fwd_b2 && tag_ready(bus.tagB_2, ready_q, bus.cdb_en_1, bus.cdb_tag_1,
                                           bus.cdb_en_2, bus.cdb_tag_2);

  assign bus.Told_1 = bus.D_en_1 ? map_q[bus.dest_1] : ZERO_TAG;
  assign bus.Told_2 = !bus.D_en_2 ? ZERO_TAG :
                      same_dest   ? bus.fl_T_1 : map_q[bus.dest_2];

  // Next map: slot 1 then slot 2 (slot 2 wins on equal dest); a restore replaces everything.
  always_comb begin
    map_mid = map_q;
    if (bus.D_en_1) map_mid[bus.dest_1] = bus.fl_T_1;
    map_all = map_mid;
    if (bus.D_en_2) map_all[bus.dest_2] = bus.fl_T_2;
    map_d = map_all;
    if (bus.br_mispredict) map_d = ckpt_q[mark_mis];
  end

  // CDB sets first so a same-cycle dispatch clear of the same tag wins.
  always_comb begin
    ready_d = ready_q;
    if (bus.cdb_en_1) ready_d[bus.cdb_tag_1] = 1'b1;
    if (bus.cdb_en_2) ready_d[bus.cdb_tag_2] = 1'b1;
    if (!bus.br_mispredict) begin
      if (bus.D_en_1) ready_d[bus.fl_T_1] = 1'b0;
      if (bus.D_en_2) ready_d[bus.fl_T_2] = 1'b0;
    end
    ready_d[ZERO_TAG] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) map_q[i] <= 6'(i);
      ready_q <= '1;
      for (int c = 0; c < NUM_CKPT; c++)
        for (int i = 0; i < 32; i++) ckpt_q[c][i] <= 6'(i);
    end else begin
      map_q   <= map_d;
      ready_q <= ready_d;
      if (ckpt_wr_1) ckpt_q[mark_1] <= map_mid;
      if (ckpt_wr_2) ckpt_q[mark_2] <= map_all;
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Bench for map_table: directed scenarios plus randomized traffic against an array-based
// model of the rename map, ready vector and checkpoints.
module tb_map_table;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  map_table_if bus ();
  map_table dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  int m_map  [32];
  bit m_ready[64];
  int m_ckpt [4][32];
  int e_tag  [4];
  bit e_rdy  [4];
  int e_told [2];
  logic [6:0] exp_q[$];

  task automatic clear_inputs();
    bus.D_en_1 = 0; bus.D_en_2 = 0; bus.dest_1 = 0; bus.dest_2 = 0;
    bus.srcA_1 = 0; bus.srcB_1 = 0; bus.srcA_2 = 0; bus.srcB_2 = 0;
    bus.fl_T_1 = 0; bus.fl_T_2 = 0;
    bus.cdb_en_1 = 0; bus.cdb_en_2 = 0; bus.cdb_tag_1 = 0; bus.cdb_tag_2 = 0;
    bus.br_wr_en_1 = 0; bus.br_wr_en_2 = 0; bus.br_marker_in_1 = 0; bus.br_marker_in_2 = 0;
    bus.br_mispredict = 0; bus.br_mispre_marker = 0;
  endtask

  function automatic bit m_rdy(int tag);
    return (tag == 31) || m_ready[tag] || (bus.cdb_en_1 && int'(bus.cdb_tag_1) == tag)
           || (bus.cdb_en_2 && int'(bus.cdb_tag_2) == tag);
  endfunction

  function automatic void compute_expected();
    int srcs[4];
    srcs = '{int'(bus.srcA_1), int'(bus.srcB_1), int'(bus.srcA_2), int'(bus.srcB_2)};
    for (int k = 0; k < 4; k++) begin
      if (k >= 2 && bus.D_en_1 && srcs[k] == int'(bus.dest_1)) begin
        e_tag[k] = int'(bus.fl_T_1); e_rdy[k] = 0;
      end else begin
        e_tag[k] = m_map[srcs[k]]; e_rdy[k] = m_rdy(e_tag[k]);
      end
    end
    e_told[0] = bus.D_en_1 ? m_map[bus.dest_1] : 31;
    if (!bus.D_en_2) e_told[1] = 31;
    else if (bus.D_en_1 && bus.dest_1 == bus.dest_2) e_told[1] = int'(bus.fl_T_1);
    else e_told[1] = m_map[bus.dest_2];
  endfunction

  // Model of one clock edge, applied with the inputs that were present at that edge.
  function automatic void model_step();
    int after1[32];
    int after2[32];
    if (reset) begin
      for (int i = 0; i < 32; i++) m_map[i] = i;
      for (int i = 0; i < 64; i++) m_ready[i] = 1;
      for (int c = 0; c < 4; c++) for (int i = 0; i < 32; i++) m_ckpt[c][i] = i;
      return;
    end
    if (bus.cdb_en_1) m_ready[bus.cdb_tag_1] = 1;
    if (bus.cdb_en_2) m_ready[bus.cdb_tag_2] = 1;
    if (bus.br_mispredict) begin
      m_map = m_ckpt[bus.br_mispre_marker % 4];
    end else begin
      if (bus.D_en_1) m_ready[bus.fl_T_1] = 0;
      if (bus.D_en_2) m_ready[bus.fl_T_2] = 0;
      after1 = m_map;
      if (bus.D_en_1) after1[bus.dest_1] = int'(bus.fl_T_1);
      after2 = after1;
      if (bus.D_en_2) after2[bus.dest_2] = int'(bus.fl_T_2);
      if (bus.br_wr_en_1 && !bus.br_wr_en_2) m_ckpt[bus.br_marker_in_1 % 4] = after1;
      if (bus.br_wr_en_2 && !bus.br_wr_en_1) m_ckpt[bus.br_marker_in_2 % 4] = after2;
      m_map = after2;
    end
    m_ready[31] = 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    tick(); tick();
    reset = 0;
    bus.srcA_1 = 5; bus.srcB_1 = 31; #1;
    n_checks++; if (bus.tagA_1 !== 6'd5) begin n_errors++; $display("FAIL reset_tagA_1: got %0d expected 5", bus.tagA_1); end
    n_checks++; if (bus.rdyA_1 !== 1'b1) begin n_errors++; $display("FAIL reset_rdyA_1: got %b expected 1", bus.rdyA_1); end
    n_checks++; if (bus.tagB_1 !== 6'd31) begin n_errors++; $display("FAIL reset_tagB_1: got %0d expected 31", bus.tagB_1); end
    n_checks++; if (bus.rdyB_1 !== 1'b1) begin n_errors++; $display("FAIL reset_rdyB_1: got %b expected 1", bus.rdyB_1); end
    n_checks++; if (bus.Told_1 !== 6'd31) begin n_errors++; $display("FAIL idle_Told_1: got %0d expected 31", bus.Told_1); end
  endtask

  task automatic test_dispatch();
    clear_inputs();
    bus.D_en_1 = 1; bus.dest_1 = 3; bus.fl_T_1 = 32; #1;
    n_checks++; if (bus.Told_1 !== 6'd3) begin n_errors++; $display("FAIL disp_Told_1: got %0d expected 3", bus.Told_1); end
    tick(); clear_inputs();
    bus.srcA_1 = 3; #1;
    n_checks++; if (bus.tagA_1 !== 6'd32) begin n_errors++; $display("FAIL disp_tagA_1: got %0d expected 32", bus.tagA_1); end
    n_checks++; if (bus.rdyA_1 !== 1'b0) begin n_errors++; $display("FAIL disp_rdyA_1: got %b expected 0", bus.rdyA_1); end
  endtask

  task automatic test_pair();
    clear_inputs();
    bus.D_en_1 = 1; bus.dest_1 = 7; bus.fl_T_1 = 33;
    bus.D_en_2 = 1; bus.dest_2 = 7; bus.fl_T_2 = 34; bus.srcA_2 = 7; bus.srcB_2 = 3; #1;
    n_checks++; if (bus.tagA_2 !== 6'd33) begin n_errors++; $display("FAIL pair_tagA_2: got %0d expected 33", bus.tagA_2); end
    n_checks++; if (bus.rdyA_2 !== 1'b0) begin n_errors++; $display("FAIL pair_rdyA_2: got %b expected 0", bus.rdyA_2); end
    n_checks++; if (bus.Told_2 !== 6'd33) begin n_errors++; $display("FAIL pair_Told_2: got %0d expected 33", bus.Told_2); end
    n_checks++; if (bus.Told_1 !== 6'd7) begin n_errors++; $display("FAIL pair_Told_1: got %0d expected 7", bus.Told_1); end
    n_checks++; if (bus.tagB_2 !== 6'd32) begin n_errors++; $display("FAIL pair_tagB_2: got %0d expected 32", bus.tagB_2); end
    tick(); clear_inputs();
    bus.srcA_1 = 7; #1;
    n_checks++; if (bus.tagA_1 !== 6'd34) begin n_errors++; $display("FAIL pair_map7: got %0d expected 34", bus.tagA_1); end
  endtask

  task automatic test_cdb_bypass();
    clear_inputs();
    bus.srcA_1 = 3; bus.srcB_1 = 7; bus.cdb_en_1 = 1; bus.cdb_tag_1 = 32; #1;
    n_checks++; if (bus.rdyA_1 !== 1'b1) begin n_errors++; $display("FAIL cdb_bypass_rdyA_1: got %b expected 1", bus.rdyA_1); end
    n_checks++; if (bus.rdyB_1 !== 1'b0) begin n_errors++; $display("FAIL cdb_other_rdyB_1: got %b expected 0", bus.rdyB_1); end
    bus.cdb_en_1 = 0; bus.cdb_en_2 = 1; bus.cdb_tag_2 = 34; #1;
    n_checks++; if (bus.rdyB_1 !== 1'b1) begin n_errors++; $display("FAIL cdb2_bypass_rdyB_1: got %b expected 1", bus.rdyB_1); end
    bus.cdb_en_1 = 1;
    tick(); clear_inputs();
    bus.srcA_1 = 3; bus.srcB_1 = 7; #1;
    n_checks++; if (bus.rdyA_1 !== 1'b1) begin n_errors++; $display("FAIL cdb_latched_rdyA_1: got %b expected 1", bus.rdyA_1); end
    n_checks++; if (bus.rdyB_1 !== 1'b1) begin n_errors++; $display("FAIL cdb_latched_rdyB_1: got %b expected 1", bus.rdyB_1); end
  endtask

  task automatic test_checkpoint();
    clear_inputs();
    bus.D_en_1 = 1; bus.dest_1 = 4; bus.fl_T_1 = 35;
    bus.D_en_2 = 1; bus.dest_2 = 6; bus.fl_T_2 = 36;
    bus.br_wr_en_1 = 1; bus.br_marker_in_1 = 2;
    tick(); clear_inputs();
    bus.D_en_1 = 1; bus.dest_1 = 4; bus.fl_T_1 = 40;
    tick(); clear_inputs();
    bus.srcA_1 = 4; #1;
    n_checks++; if (bus.tagA_1 !== 6'd40) begin n_errors++; $display("FAIL ckpt_pre_map4: got %0d expected 40", bus.tagA_1); end
    // Restore with a dispatch and a checkpoint write in the same cycle; both must be dropped.
    bus.br_mispredict = 1; bus.br_mispre_marker = 2;
    bus.D_en_1 = 1; bus.dest_1 = 4; bus.fl_T_1 = 41;
    bus.D_en_2 = 1; bus.dest_2 = 6; bus.fl_T_2 = 42;
    bus.br_wr_en_2 = 1; bus.br_marker_in_2 = 2;
    tick(); clear_inputs();
    bus.srcA_1 = 4; bus.srcB_1 = 6; bus.srcA_2 = 3; #1;
    n_checks++; if (bus.tagA_1 !== 6'd35) begin n_errors++; $display("FAIL restore_map4: got %0d expected 35", bus.tagA_1); end
    n_checks++; if (bus.tagB_1 !== 6'd6) begin n_errors++; $display("FAIL restore_map6: got %0d expected 6", bus.tagB_1); end
    n_checks++; if (bus.tagA_2 !== 6'd32) begin n_errors++; $display("FAIL restore_map3: got %0d expected 32", bus.tagA_2); end
    n_checks++; if (bus.rdyA_1 !== 1'b0) begin n_errors++; $display("FAIL restore_rdy35: got %b expected 0", bus.rdyA_1); end
    clear_inputs();
    bus.D_en_1 = 1; bus.dest_1 = 4; bus.fl_T_1 = 44; tick(); clear_inputs();
    bus.br_mispredict = 1; bus.br_mispre_marker = 2; tick(); clear_inputs();
    bus.srcA_1 = 4; bus.srcB_1 = 6; #1;
    n_checks++; if (bus.tagA_1 !== 6'd35) begin n_errors++; $display("FAIL ckpt_kept_map4: got %0d expected 35", bus.tagA_1); end
    n_checks++; if (bus.tagB_1 !== 6'd6) begin n_errors++; $display("FAIL ckpt_kept_map6: got %0d expected 6", bus.tagB_1); end
    // Slot-2 checkpoint captures both slots; marker bit 2 does not select the entry.
    clear_inputs();
    bus.D_en_1 = 1; bus.dest_1 = 9; bus.fl_T_1 = 45;
    bus.D_en_2 = 1; bus.dest_2 = 10; bus.fl_T_2 = 46;
    bus.br_wr_en_2 = 1; bus.br_marker_in_2 = 3'b101;
    tick(); clear_inputs();
    bus.D_en_1 = 1; bus.dest_1 = 9; bus.fl_T_1 = 47; tick(); clear_inputs();
    bus.br_mispredict = 1; bus.br_mispre_marker = 3'b001; tick(); clear_inputs();
    bus.srcA_1 = 9; bus.srcB_1 = 10; #1;
    n_checks++; if (bus.tagA_1 !== 6'd45) begin n_errors++; $display("FAIL ckpt2_map9: got %0d expected 45", bus.tagA_1); end
    n_checks++; if (bus.tagB_1 !== 6'd46) begin n_errors++; $display("FAIL ckpt2_map10: got %0d expected 46", bus.tagB_1); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    bus.D_en_1 = 1; bus.dest_1 = 4; bus.fl_T_1 = 50;
    bus.br_mispredict = 1; bus.br_mispre_marker = 2; reset = 1;
    tick(); reset = 0; clear_inputs();
    bus.srcA_1 = 4; bus.srcB_1 = 9; bus.srcA_2 = 7; bus.srcB_2 = 3; #1;
    n_checks++; if (bus.tagA_1 !== 6'd4 || bus.rdyA_1 !== 1'b1) begin n_errors++; $display("FAIL rstmid_map4: got %0d/%b expected 4/1", bus.tagA_1, bus.rdyA_1); end
    n_checks++; if (bus.tagB_1 !== 6'd9 || bus.rdyB_1 !== 1'b1) begin n_errors++; $display("FAIL rstmid_map9: got %0d/%b expected 9/1", bus.tagB_1, bus.rdyB_1); end
    n_checks++; if (bus.tagA_2 !== 6'd7 || bus.rdyA_2 !== 1'b1) begin n_errors++; $display("FAIL rstmid_map7: got %0d/%b expected 7/1", bus.tagA_2, bus.rdyA_2); end
    n_checks++; if (bus.tagB_2 !== 6'd3 || bus.rdyB_2 !== 1'b1) begin n_errors++; $display("FAIL rstmid_map3: got %0d/%b expected 3/1", bus.tagB_2, bus.rdyB_2); end
  endtask

  function automatic logic [5:0] rand_tag();
    int t;
    t = $urandom_range(0, 62);
    if (t >= 31) t++;
    return 6'(t);
  endfunction

  task automatic test_random(int cycles);
    string names[10] = '{"tagA_1", "rdyA_1", "tagB_1", "rdyB_1", "tagA_2", "rdyA_2",
                         "tagB_2", "rdyB_2", "Told_1", "Told_2"};
    logic [6:0] obs[10];
    logic [6:0] exp_v;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      clear_inputs();
      reset = ($urandom_range(0, 99) == 0);
      bus.D_en_1 = ($urandom_range(0, 9) < 7);
      bus.D_en_2 = ($urandom_range(0, 9) < 7);
      bus.dest_1 = 5'($urandom_range(0, 30));
      bus.dest_2 = ($urandom_range(0, 3) == 0) ? bus.dest_1 : 5'($urandom_range(0, 30));
      bus.srcA_1 = 5'($urandom_range(0, 31)); bus.srcB_1 = 5'($urandom_range(0, 31));
      bus.srcA_2 = ($urandom_range(0, 3) == 0) ? bus.dest_1 : 5'($urandom_range(0, 31));
      bus.srcB_2 = 5'($urandom_range(0, 31));
      bus.fl_T_1 = rand_tag();
      do bus.fl_T_2 = rand_tag(); while (bus.fl_T_2 == bus.fl_T_1);
      bus.cdb_en_1 = $urandom_range(0, 1); bus.cdb_tag_1 = 6'($urandom_range(0, 63));
      bus.cdb_en_2 = $urandom_range(0, 1); bus.cdb_tag_2 = 6'($urandom_range(0, 63));
      bus.br_wr_en_1 = ($urandom_range(0, 9) < 2); bus.br_marker_in_1 = 3'($urandom_range(0, 7));
      bus.br_wr_en_2 = ($urandom_range(0, 9) < 2); bus.br_marker_in_2 = 3'($urandom_range(0, 7));
      bus.br_mispredict = ($urandom_range(0, 11) == 0);
      bus.br_mispre_marker = 3'($urandom_range(0, 7));
      #1;
      compute_expected();
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({1'b0, 6'(e_tag[k])});
        exp_q.push_back({6'b0, e_rdy[k]});
      end
      exp_q.push_back({1'b0, 6'(e_told[0])});
      exp_q.push_back({1'b0, 6'(e_told[1])});
      obs = '{{1'b0, bus.tagA_1}, {6'b0, bus.rdyA_1}, {1'b0, bus.tagB_1}, {6'b0, bus.rdyB_1},
              {1'b0, bus.tagA_2}, {6'b0, bus.rdyA_2}, {1'b0, bus.tagB_2}, {6'b0, bus.rdyB_2},
              {1'b0, bus.Told_1}, {1'b0, bus.Told_2}};
      for (int k = 0; k < 10; k++) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs[k] !== exp_v) begin
          n_errors++;
          $display("FAIL rand_%s cycle %0d: got %0d expected %0d", names[k], cyc, obs[k], exp_v);
        end
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_dispatch();
    test_pair();
    test_cdb_bypass();
    test_checkpoint();
    test_reset_mid();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
